// File: rtl/vga_video_tx_pkg.sv
// Shared types and defaults for the VGA transmitter.
//   vga_timing_t : one complete set of horizontal/vertical timing values
//   VGA_640X480  : 640x480@60 timing, used as the module parameter defaults
//   state_e      : lock FSM states
//   rgb444_t     : 4:4:4 colour word, {r, g, b}
package vga_video_tx_pkg;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
   };

   typedef enum logic {
      SYNC_WAIT = 1'b0,
      RUN       = 1'b1
   } state_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Counter width for a 0..total-1 count; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned total);
      return (total > 1) ? int'($clog2(total)) : 1;
   endfunction

endpackage

// File: rtl/vga_video_tx_if.sv
// Upstream pixel stream into the VGA transmitter.
//   pix_valid : word valid (source)
//   pix_ready : word consumed this cycle when pix_valid is also high (sink)
//   pix_rgb   : 4:4:4 colour word (source)
//   pix_sof   : first pixel of a frame (source)
interface vga_video_tx_if;
   import vga_video_tx_pkg::*;

   logic    pix_valid;
   logic    pix_ready;
   rgb444_t pix_rgb;
   logic    pix_sof;

   modport master (output pix_valid, output pix_rgb, output pix_sof, input pix_ready);
   modport slave  (input pix_valid, input pix_rgb, input pix_sof, output pix_ready);

endinterface

// File: rtl/vga_video_tx_timing_counter.sv
// Horizontal/vertical raster counters and their position decodes.
//   pixel_clk, rst : clock, async active-high reset
//   enable         : 0 forces both counters to 0 on the next edge
//   active         : current position is inside the visible area
//   hs_int, vs_int : current position is inside the sync pulse (polarity-free)
//   at_origin      : current position is (0,0)
// Line order is active, front porch, sync, back porch.
module vga_timing_counter
   import vga_video_tx_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_640X480.h_active,
   parameter int unsigned H_FP     = VGA_640X480.h_fp,
   parameter int unsigned H_SYNC   = VGA_640X480.h_sync,
   parameter int unsigned H_BP     = VGA_640X480.h_bp,
   parameter int unsigned V_ACTIVE = VGA_640X480.v_active,
   parameter int unsigned V_FP     = VGA_640X480.v_fp,
   parameter int unsigned V_SYNC   = VGA_640X480.v_sync,
   parameter int unsigned V_BP     = VGA_640X480.v_bp
) (
   input  logic pixel_clk,
   input  logic rst,
   input  logic enable,
   output logic active,
   output logic hs_int,
   output logic vs_int,
   output logic at_origin
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW = cnt_width(H_TOTAL);
   localparam int unsigned VW = cnt_width(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!enable) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
         h_cnt_d = h_cnt_q + HW'(1);
      end
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign hs_int    = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
   assign vs_int    = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
   assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_video_tx.sv
// VGA transmitter: raster timing plus 4:4:4 RGB taken from an upstream stream.
//   pixel_clk, rst  : clock, async active-high reset
//   enable          : 0 idles all outputs and holds the raster at (0,0)
//   pix             : pixel stream sink (valid/ready/rgb/sof)
//   vga_r/g/b       : registered colour, 0 outside the visible area
//   vga_hsync/vsync : registered sync, asserted level set by HS_POL/VS_POL
//   frame_start     : pulse with pixel (0,0) on the VGA outputs
//   underflow       : pulse, visible pixel needed but no word was valid
//   frame_err       : pulse, SOF arrived away from (0,0)
//   locked          : stream is locked to the raster
//
// state     | meaning
// SYNC_WAIT | not locked; non-SOF words dropped, SOF word held until (0,0)
// RUN       | locked; one word consumed per visible pixel
module vga_video_tx
   import vga_video_tx_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_640X480.h_active,
   parameter int unsigned H_FP     = VGA_640X480.h_fp,
   parameter int unsigned H_SYNC   = VGA_640X480.h_sync,
   parameter int unsigned H_BP     = VGA_640X480.h_bp,
   parameter int unsigned V_ACTIVE = VGA_640X480.v_active,
   parameter int unsigned V_FP     = VGA_640X480.v_fp,
   parameter int unsigned V_SYNC   = VGA_640X480.v_sync,
   parameter int unsigned V_BP     = VGA_640X480.v_bp,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic            pixel_clk,
   input  logic            rst,
   input  logic            enable,
   vga_video_tx_if.slave   pix,
   output logic [3:0]      vga_r,
   output logic [3:0]      vga_g,
   output logic [3:0]      vga_b,
   output logic            vga_hsync,
   output logic            vga_vsync,
   output logic            frame_start,
   output logic            underflow,
   output logic            frame_err,
   output logic            locked
);

   logic active, hs_int, vs_int, at_origin;

   vga_timing_counter #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .enable    (enable),
      .active    (active),
      .hs_int    (hs_int),
      .vs_int    (vs_int),
      .at_origin (at_origin)
   );

   state_e  state_q, state_d;
   rgb444_t rgb_q, rgb_d;
   logic    hsync_q, hsync_d;
   logic    vsync_q, vsync_d;
   logic    fs_q, fs_d;
   logic    uf_q, uf_d;
   logic    fe_q, fe_d;
   logic    ready_c;

   always_comb begin
      state_d = state_q;
      rgb_d   = '0;
      hsync_d = ~HS_POL;
      vsync_d = ~VS_POL;
      fs_d    = 1'b0;
      uf_d    = 1'b0;
      fe_d    = 1'b0;
      ready_c = 1'b0;
      if (!enable) begin
         state_d = SYNC_WAIT;
      end else begin
         hsync_d = hs_int ? HS_POL : ~HS_POL;
         vsync_d = vs_int ? VS_POL : ~VS_POL;
         fs_d    = at_origin;
         unique case (state_q)
            SYNC_WAIT: begin
               if (pix.pix_valid && pix.pix_sof) begin
                  // The SOF word waits here (not consumed) until the raster reaches (0,0).
                  if (at_origin) begin
                     ready_c = 1'b1;
                     rgb_d   = pix.pix_rgb;
                     state_d = RUN;
                  end
               end else begin
                  ready_c = pix.pix_valid;
               end
            end
            RUN: begin
               if (active) begin
                  ready_c = 1'b1;
                  if (!pix.pix_valid) begin
                     uf_d    = 1'b1;
                     state_d = SYNC_WAIT;
                  end else if (pix.pix_sof && !at_origin) begin
                     // Leave the misplaced SOF word in place so it can start the next frame.
                     ready_c = 1'b0;
                     fe_d    = 1'b1;
                     state_d = SYNC_WAIT;
                  end else begin
                     rgb_d = pix.pix_rgb;
                  end
               end
            end
            default: state_d = SYNC_WAIT;
         endcase
      end
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state_q <= SYNC_WAIT;
         rgb_q   <= '0;
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
         fe_q    <= fe_d;
      end
   end

   // Ready is combinational, so it is masked while reset is held to keep the source from
   // seeing a handshake that the held-in-reset datapath cannot honour.
   assign pix.pix_ready = ready_c & ~rst;

   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign frame_start = fs_q;
   assign underflow   = uf_q;
   assign frame_err   = fe_q;
   assign locked      = (state_q == RUN);

endmodule

// File: tb/tb_vga_video_tx.sv
module tb_vga_video_tx;

   localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
   localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
   localparam int HT = HA + HF + HSW + HB;   // 14
   localparam int VT = VA + VF + VSW + VB;   // 7
   localparam int FT = HT * VT;              // 98
   localparam int N  = 398;

   logic       pixel_clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       vga_hsync, vga_vsync, frame_start, underflow, frame_err, locked;

   vga_video_tx_if pix_if ();

   vga_video_tx #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
      .HS_POL (1'b0), .VS_POL (1'b0)
   ) dut (
      .pixel_clk   (pixel_clk),
      .rst         (rst),
      .enable      (enable),
      .pix         (pix_if),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .frame_start (frame_start),
      .underflow   (underflow),
      .frame_err   (frame_err),
      .locked      (locked)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      logic        en;
      logic        valid;
      logic        sof;
      logic [11:0] rgb;
      logic        exp_ready;
      logic [11:0] exp_rgb;
      logic        exp_hs;
      logic        exp_vs;
      logic        exp_fs;
      logic        exp_uf;
      logic        exp_fe;
      logic        exp_locked;
   } vec_t;

   vec_t vt [N];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] pack(input logic [11:0] rgb, input logic hs, input logic vs,
                                        input logic fs, input logic uf, input logic fe, input logic lk);
      return {rgb, hs, vs, fs, uf, fe, lk};
   endfunction

   function automatic logic [17:0] outs();
      return pack({vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, frame_start, underflow, frame_err, locked);
   endfunction

   function automatic bit is_act(input int c);
      return ((c % HT) < HA) && (((c / HT) % VT) < VA);
   endfunction

   localparam logic [17:0] IDLE_OUT = 18'b0000_0000_0000_11_0000;

   task automatic fill_table();
      int k;
      int j;
      for (int c = 0; c < N; c++) begin
         int hp, vp;
         vt[c].en = 1'b1; vt[c].valid = 1'b0; vt[c].sof = 1'b0; vt[c].rgb = '0;
         vt[c].exp_ready = 1'b0; vt[c].exp_rgb = '0;
         vt[c].exp_uf = 1'b0; vt[c].exp_fe = 1'b0; vt[c].exp_locked = 1'b0;
         if (c == 0) begin
            vt[c].exp_hs = 1'b1; vt[c].exp_vs = 1'b1; vt[c].exp_fs = 1'b0;
         end else begin
            hp = (c - 1) % HT;
            vp = ((c - 1) / HT) % VT;
            vt[c].exp_hs = !(hp >= HA + HF && hp < HA + HF + HSW);
            vt[c].exp_vs = !(vp >= VA + VF && vp < VA + VF + VSW);
            vt[c].exp_fs = ((c - 1) % FT) == 0;
         end
      end
      // frame 0 has no stream; three non-SOF words arrive just before frame 1 and are dropped
      for (int i = 0; i < 3; i++) begin
         vt[95+i].valid = 1'b1; vt[95+i].rgb = 12'(12'hF0A + i); vt[95+i].exp_ready = 1'b1;
      end
      // frames 1..2: always-valid stream 0x001.. with SOF first, underflow at (3,1) of frame 2
      k = 1;
      for (int c = 98; c < 213; c++) begin
         vt[c].valid = 1'b1; vt[c].rgb = 12'(k); vt[c].sof = (c == 98);
         if (is_act(c)) begin
            vt[c].exp_ready = 1'b1; vt[c+1].exp_rgb = 12'(k); k++;
         end
      end
      vt[213].exp_ready = 1'b1;
      vt[214].exp_uf = 1'b1;
      // frame 3: relock, then SOF misplaced at (5,2) and held to frame 4's origin
      j = 0;
      for (int c = 294; c < 327; c++) begin
         vt[c].valid = 1'b1; vt[c].rgb = 12'(12'h100 + j); vt[c].sof = (c == 294);
         if (is_act(c)) begin
            vt[c].exp_ready = 1'b1; vt[c+1].exp_rgb = vt[c].rgb; j++;
         end
      end
      for (int c = 327; c < 392; c++) begin
         vt[c].valid = 1'b1; vt[c].sof = 1'b1; vt[c].rgb = 12'hABC;
      end
      vt[328].exp_fe = 1'b1;
      vt[392].valid = 1'b1; vt[392].sof = 1'b1; vt[392].rgb = 12'hABC; vt[392].exp_ready = 1'b1;
      vt[393].exp_rgb = 12'hABC;
      for (int c = 393; c < N; c++) begin
         vt[c].valid = 1'b1; vt[c].rgb = 12'(12'hB00 + (c - 392)); vt[c].exp_ready = 1'b1;
         if (c + 1 < N) vt[c+1].exp_rgb = vt[c].rgb;
      end
      for (int c = 99;  c <= 213; c++) vt[c].exp_locked = 1'b1;
      for (int c = 295; c <= 327; c++) vt[c].exp_locked = 1'b1;
      for (int c = 393; c < N;    c++) vt[c].exp_locked = 1'b1;
   endtask

   initial begin
      fill_table();
      rst = 1'b1;
      enable = 1'b0;
      pix_if.pix_valid = 1'b0;
      pix_if.pix_sof   = 1'b0;
      pix_if.pix_rgb   = '0;

      repeat (2) @(posedge pixel_clk);
      #1;
      check("reset_out", outs(), IDLE_OUT);
      check("reset_ready", pix_if.pix_ready, 1'b0);
      rst = 1'b0;
      @(posedge pixel_clk); #1;
      check("idle_out", outs(), IDLE_OUT);
      check("idle_ready", pix_if.pix_ready, 1'b0);

      for (int c = 0; c < N; c++) begin
         enable           = vt[c].en;
         pix_if.pix_valid = vt[c].valid;
         pix_if.pix_sof   = vt[c].sof;
         pix_if.pix_rgb   = vt[c].rgb;
         #2;
         check($sformatf("vec%0d_ready", c), pix_if.pix_ready, vt[c].exp_ready);
         check($sformatf("vec%0d_out", c), outs(),
               pack(vt[c].exp_rgb, vt[c].exp_hs, vt[c].exp_vs, vt[c].exp_fs,
                    vt[c].exp_uf, vt[c].exp_fe, vt[c].exp_locked));
         @(posedge pixel_clk); #1;
      end

      // async reset mid-frame while locked and streaming
      pix_if.pix_valid = 1'b1;
      pix_if.pix_sof   = 1'b0;
      pix_if.pix_rgb   = 12'hB06;
      #2;
      check("pre_reset_out", outs(), pack(12'hB05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      rst = 1'b1;
      #1;
      check("midframe_reset_out", outs(), IDLE_OUT);
      check("midframe_reset_ready", pix_if.pix_ready, 1'b0);
      #1;
      rst = 1'b0;

      // after release the raster restarts at (0,0): hsync low in cycles 11 and 12
      for (int i = 1; i <= 11; i++) begin
         @(posedge pixel_clk); #2;
         check($sformatf("post_reset_hs%0d", i), vga_hsync, (i == 11) ? 1'b0 : 1'b1);
         check($sformatf("post_reset_lock%0d", i), locked, 1'b0);
      end
      check("discard_ready", pix_if.pix_ready, 1'b1);

      // enable drop mid-line, right when the next hsync output would stay low
      enable = 1'b0;
      #1;
      check("disable_ready", pix_if.pix_ready, 1'b0);
      @(posedge pixel_clk); #2;
      check("disable_out", outs(), IDLE_OUT);
      @(posedge pixel_clk); #2;
      check("disable_hold_out", outs(), IDLE_OUT);
      enable = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(posedge pixel_clk); #2;
         check($sformatf("reenable_hs%0d", i), vga_hsync, (i == 11 || i == 12) ? 1'b0 : 1'b1);
         check($sformatf("reenable_vs%0d", i), vga_vsync, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
